spi_byte_fifo: RTL
==================

# spi_byte_fifo

Synchronous first-word-fall-through byte FIFO that buffers SPI data between the register/bus interface and the SPI transfer controller. One instance is the write FIFO: the bus pushes bytes and the controller pops them through `w_fifo_en`, using `empty` as `w_fifo_empty`. A second instance is the read FIFO: the shift datapath pushes received bytes on `r_fifo_en`, and the bus pops them. The head entry is always visible on `rd_data`, so the controller can load a byte in the same cycle it pops it.

## Interface
- `DATA_W`, default 8: entry width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2. The default matches the controller's 4-block burst.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `clr`  in  1  synchronous flush: empties the FIFO and clears the error flags.
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_W  push data.
- `rd_en`  in  1  pop request, acknowledging the current `rd_data`.
- `rd_data`  out  DATA_W  head entry. Reads 0 when the FIFO is empty.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: a push was dropped.
- `underflow`  out  1  sticky flag: a pop was ignored.

## Operation
- Storage is DEPTH×DATA_W registers. The array is not reset.
- `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - `count` = `wr_ptr` − `rd_ptr`, computed modulo 2^($clog2(DEPTH)+1).
- A push is accepted when `wr_en` is high and either:
  - the FIFO is not full, or
  - the FIFO is full and a pop is accepted in the same cycle.
  On acceptance, `wr_data` is written at `wr_ptr`, and `wr_ptr` increments and wraps naturally.
- A pop is accepted when `rd_en` is high and the FIFO is not empty; `rd_ptr` then increments.
- Push and pop in the same cycle:
  - Not empty: both are accepted and `count` is unchanged.
  - Empty: the push is accepted, the pop is ignored, and `underflow` is set. No bypass: the pushed byte appears on `rd_data` the next cycle.
  - Full: both are accepted and `full` stays high.
- A rejected push sets `overflow`. A rejected pop sets `underflow`. Both flags hold until `reset` or `clr`.
- `rd_data` is `mem[rd_ptr index]` when not empty and 0 when empty. It is combinational from registered state only.
- Priority: `reset` > `clr` > push/pop. A `clr` in the same cycle as `wr_en` discards the push.

## Timing
- Reset and `clr` values: `empty`=1, `full`=0, `count`=0, `rd_data`=0, `overflow`=0, `underflow`=0. Both pointers are 0.
- Push-to-visible latency is 1 cycle: `empty` falls and `rd_data` is valid in the cycle after an accepted push into an empty FIFO.
- A pop takes effect at the clock edge. The next head appears on `rd_data` in the following cycle.
- All flags and `count` update in the cycle after the causing edge. There is no combinational path from `wr_en` or `rd_en` to any output.
- Reset mid-stream discards all contents. The first push after reset is readable 1 cycle later.
- The controller pops once at START and once per NEXT. Back-to-back pops in consecutive cycles are supported at full rate.

## Configuration
- `SPI_FIFO_ERR_FLAGS_EN`
  - Defined: `overflow` and `underflow` are implemented as described above.
  - Undefined: both outputs are tied to 0 and their registers are not generated. Dropped pushes and ignored pops are still discarded silently, so FIFO behaviour is otherwise identical.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_DATA_W` = 8
  - `SPI_FIFO_DEPTH` = 4
  - `typedef logic [SPI_DATA_W-1:0] spi_byte_t`
  
  The FIFO parameter defaults and the controller's block count both derive from these.
- One sub-module: `spi_fifo_mem`, a simple dual-port register array with one write port and one asynchronous read port. The pointer and flag logic stays in `spi_byte_fifo`.

## Test plan
- Reset, then push 0xA5 -> next cycle: `empty`=0, `count`=1, `rd_data`=0xA5. Pop -> next cycle: `empty`=1, `rd_data`=0.
- Push 0x11, 0x22, 0x33, 0x44 -> `full`=1, `count`=4. Push 0x55 -> `overflow`=1, `count`=4. Pop four times -> data reads 0x11..0x44 in order.
- Full FIFO, push 0x66 and pop in the same cycle -> 0x11 is popped, `full` stays 1, and after draining the last byte read is 0x66.
- Empty FIFO, push 0x77 and pop in the same cycle -> `underflow`=1, `count`=1, `rd_data`=0x77.
- Pointer wrap: 10 cycles of interleaved single push/pop with data 0x00..0x09 -> output order is preserved across the wrap and `count` never exceeds 1.
- FIFO holding 3 entries, assert `clr` together with `wr_en` -> next cycle: `count`=0, `empty`=1, flags 0. Repeat with `reset` mid-stream -> same result.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI block constants: byte width and FIFO depth used by the
// FIFOs and the transfer controller's burst length.
package spi_pkg;
   localparam int SPI_DATA_W     = 8;
   localparam int SPI_FIFO_DEPTH = 4;

   typedef logic [SPI_DATA_W-1:0] spi_byte_t;
endpackage

// File: rtl/spi_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module spi_fifo_mem
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W,
   parameter int DEPTH  = SPI_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through byte FIFO between the SPI bus interface and the
// transfer controller. Sticky error flags exist only with SPI_FIFO_ERR_FLAGS_EN.
module spi_byte_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W,
   parameter int DEPTH  = SPI_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              push_ok;
   logic              pop_ok;
   logic [DATA_W-1:0] head;

   // wr_en/rd_en are single-cycle requests with no backpressure signal:
   // a push is taken when space exists (or a pop frees a slot the same
   // cycle), a pop when data exists; anything else is dropped and flagged.
   assign pop_ok  = rd_en && !empty;
   assign push_ok = wr_en && (!full || pop_ok);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   spi_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok && !clr && !reset),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   assign rd_data = empty ? '0 : head;

`ifdef SPI_FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en && !push_ok) begin
            overflow_q <= 1'b1;
         end
         if (rd_en && !pop_ok) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
